alu_seq: RTL and testbench

Parametrised, registered successor to the 8-bit datapath ALU. Same opcode set and flag outputs, plus a start/done handshake, registered results and a multi-cycle shift-add unsigned multiply with a high-half output. Sits between the register file read ports and the writeback mux. The controller issues `start` and stalls on `busy`.

---
 rtl/alu_seq.sv | 156 +++++++++++++++
 tb/tb_alu_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with a start/done handshake and a multi-cycle shift-add
// unsigned multiply that also returns the high half of the product.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic             overflow,
    output logic             BranchFlag
);

    localparam int               CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST   = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WLIM   = WIDTH'(WIDTH);
    localparam logic [3:0]       OP_MUL = 4'b1010;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t             r_state, w_state_nxt;
    logic [2*WIDTH-1:0] r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_y, w_y_nxt;
    logic [WIDTH-1:0]   r_hi, w_hi_nxt;
    logic               r_ovf, w_ovf_nxt;
    logic               r_done, w_done_nxt;
    logic [WIDTH:0]     w_alu;
    logic [2*WIDTH-1:0] w_sum;

    // Single-cycle opcodes; MSB of the result is carry/borrow, zero elsewhere.
    function automatic logic [WIDTH:0] alu_op(input logic [3:0] op,
                                              input logic [WIDTH-1:0] opa,
                                              input logic [WIDTH-1:0] opb);
        logic [WIDTH:0] res;
        case (op)
            4'b0000: res = {1'b0, opa} + {1'b0, opb};
            4'b0001: res = {1'b0, opa} - {1'b0, opb};
            4'b0010: res = {1'b0, opa & opb};
            4'b0011: res = {1'b0, opa | opb};
            4'b1000: res = {1'b0, opa ^ opb};
            4'b0100: res = {1'b0, opb};
            4'b0101: res = {{WIDTH{1'b0}}, &opb};
            4'b0110: res = {{WIDTH{1'b0}}, |opb};
            4'b0111: res = (opb >= WLIM) ? {(WIDTH+1){1'b0}} : {1'b0, opa << opb};
            4'b1001: res = (opb >= WLIM) ? {(WIDTH+1){1'b0}} : {1'b0, opa >> opb};
            default: res = {(WIDTH+1){1'b0}};
        endcase
        return res;
    endfunction

    assign w_alu = alu_op(ALUControl, a, b);
    assign w_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mcand  <= {(2*WIDTH){1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_y      <= {WIDTH{1'b0}};
            r_hi     <= {WIDTH{1'b0}};
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_y      <= w_y_nxt;
            r_hi     <= w_hi_nxt;
            r_ovf    <= w_ovf_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && (ALUControl == OP_MUL)) w_state_nxt = S_MUL;
                else                                 w_state_nxt = S_IDLE;
            end
            S_MUL: begin
                if (r_cnt == LAST) w_state_nxt = S_IDLE;
                else               w_state_nxt = S_MUL;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and result updates; results hold unless a completion occurs.
    always_comb begin
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_y_nxt      = r_y;
        w_hi_nxt     = r_hi;
        w_ovf_nxt    = r_ovf;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (ALUControl == OP_MUL)) begin
                    w_mcand_nxt  = {{WIDTH{1'b0}}, a};
                    w_mplier_nxt = b;
                    w_acc_nxt    = {(2*WIDTH){1'b0}};
                    w_cnt_nxt    = {CW{1'b0}};
                end else if (start) begin
                    w_y_nxt    = w_alu[WIDTH-1:0];
                    w_hi_nxt   = {WIDTH{1'b0}};
                    w_ovf_nxt  = w_alu[WIDTH];
                    w_done_nxt = 1'b1;
                end else begin
                    w_done_nxt = 1'b0;
                end
            end
            S_MUL: begin
                w_acc_nxt    = w_sum;
                w_mcand_nxt  = {r_mcand[2*WIDTH-2:0], 1'b0};
                w_mplier_nxt = {1'b0, r_mplier[WIDTH-1:1]};
                w_cnt_nxt    = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                // Last iteration: w_sum already holds the full product.
                if (r_cnt == LAST) begin
                    w_y_nxt    = w_sum[WIDTH-1:0];
                    w_hi_nxt   = w_sum[2*WIDTH-1:WIDTH];
                    w_ovf_nxt  = (w_sum[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
                    w_done_nxt = 1'b1;
                end else begin
                    w_done_nxt = 1'b0;
                end
            end
            default: w_done_nxt = 1'b0;
        endcase
    end

    assign busy       = (r_state == S_MUL);
    assign done       = r_done;
    assign y          = r_y;
    assign hi         = r_hi;
    assign overflow   = r_ovf;
    assign BranchFlag = (r_y == {WIDTH{1'b0}});

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: WIDTH=8 and WIDTH=16 instances, random
// stimulus compared against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = 8'd0, b = 8'd0;
    logic [3:0]  op = 4'd0;
    logic        busy, done, overflow, bf;
    logic [7:0]  y, hi;

    logic        start16 = 1'b0;
    logic [15:0] a16 = 16'd0, b16 = 16'd0;
    logic [3:0]  op16 = 4'd0;
    logic        busy16, done16, ovf16, bf16;
    logic [15:0] y16, hi16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ALUControl(op),
        .busy(busy), .done(done), .y(y), .hi(hi), .overflow(overflow), .BranchFlag(bf)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16), .ALUControl(op16),
        .busy(busy16), .done(done16), .y(y16), .hi(hi16), .overflow(ovf16), .BranchFlag(bf16)
    );

    // Reference: unsigned arithmetic on wide integers, reduced modulo 2^w.
    function automatic void ref_model(input int w, input int rop,
                                      input longint unsigned ra, input longint unsigned rb,
                                      output longint unsigned ry, output longint unsigned rh,
                                      output logic ro);
        longint unsigned m, s;
        m  = 64'd1 << w;
        ry = 64'd0; rh = 64'd0; ro = 1'b0;
        case (rop)
            0:  begin s = ra + rb; ry = s % m; ro = (s >= m); end
            1:  begin ry = (ra + m - rb) % m; ro = (ra < rb); end
            2:  ry = ra & rb;
            3:  ry = ra | rb;
            8:  ry = ra ^ rb;
            4:  ry = rb;
            5:  ry = (rb == m - 64'd1) ? 64'd1 : 64'd0;
            6:  ry = (rb != 64'd0) ? 64'd1 : 64'd0;
            7:  ry = (rb >= 64'(w)) ? 64'd0 : (ra << rb) % m;
            9:  ry = (rb >= 64'(w)) ? 64'd0 : (ra >> rb);
            10: begin s = ra * rb; ry = s % m; rh = s / m; ro = (rh != 64'd0); end
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb);
        op = o; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({busy, done, y, hi, overflow, bf} !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b y=%h hi=%h ovf=%b bf=%b want 0 0 00 00 0 1",
                     busy, done, y, hi, overflow, bf);
        end
        checks++;
        if ({busy16, done16, y16, hi16, ovf16, bf16} !== {2'b00, 16'h0, 16'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset16 got busy=%b done=%b y=%h hi=%h ovf=%b bf=%b", busy16, done16, y16, hi16, ovf16, bf16);
        end
    endtask

    task automatic test_single();
        logic [3:0] ops [6] = '{4'd0, 4'd1, 4'd1, 4'd5, 4'd7, 4'd9};
        logic [7:0] as  [6] = '{8'd200, 8'd5, 8'd3, 8'h00, 8'h81, 8'h81};
        logic [7:0] bs  [6] = '{8'd100, 8'd5, 8'd5, 8'hFF, 8'd9, 8'd1};
        logic [7:0] ys  [6] = '{8'h2C, 8'h00, 8'hFE, 8'h01, 8'h00, 8'h40};
        longint unsigned ey, eh;
        logic eo;
        logic [3:0] o;
        logic [7:0] va, vb;
        for (int i = 0; i < 46; i++) begin
            if (i < 6) begin
                o = ops[i]; va = as[i]; vb = bs[i];
            end else begin
                o = 4'($urandom_range(0, 14));
                if (o >= 4'd10) o = o + 4'd1;
                va = 8'($urandom);
                vb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 11)) : 8'($urandom);
            end
            ref_model(8, int'(o), longint'(va), longint'(vb), ey, eh, eo);
            issue(o, va, vb);
            checks++;
            if ({done, y, hi, overflow, bf} !== {1'b1, ey[7:0], eh[7:0], eo, ey[7:0] == 8'h00}) begin
                errors++;
                $display("FAIL single op=%h a=%h b=%h got done=%b y=%h hi=%h ovf=%b bf=%b want y=%h ovf=%b",
                         o, va, vb, done, y, hi, overflow, bf, ey[7:0], eo);
            end
            if (i < 6) begin
                checks++;
                if (y !== ys[i]) begin
                    errors++;
                    $display("FAIL directed_y idx=%0d got %h want %h", i, y, ys[i]);
                end
            end
            @(posedge clk); #1;
            checks++;
            if ({done, y, overflow} !== {1'b0, ey[7:0], eo}) begin
                errors++;
                $display("FAIL single_hold op=%h got done=%b y=%h ovf=%b want 0 %h %b", o, done, y, overflow, ey[7:0], eo);
            end
        end
    endtask

    task automatic test_mul();
        logic [7:0] mas [3] = '{8'h10, 8'hFF, 8'h00};
        logic [7:0] mbs [3] = '{8'h20, 8'hFF, 8'h55};
        longint unsigned ey, eh;
        logic eo, got;
        logic [7:0] va, vb, py, ph;
        logic po;
        int busy_cycles;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) begin
                va = mas[i]; vb = mbs[i];
            end else begin
                va = 8'($urandom); vb = 8'($urandom);
            end
            py = y; ph = hi; po = overflow;
            ref_model(8, 10, longint'(va), longint'(vb), ey, eh, eo);
            issue(4'hA, va, vb);
            busy_cycles = 0;
            got = 1'b0;
            for (int n = 0; n < 40; n++) begin
                if (done) begin got = 1'b1; break; end
                checks++;
                if ({busy, y, hi, overflow} !== {1'b1, py, ph, po}) begin
                    errors++;
                    $display("FAIL mul_busy_hold cyc=%0d got busy=%b y=%h hi=%h ovf=%b", n, busy, y, hi, overflow);
                end
                busy_cycles++;
                start = ($urandom_range(0, 1) == 1);
                op = 4'd0; a = 8'($urandom); b = 8'($urandom);
                @(posedge clk); #1;
            end
            start = 1'b0;
            checks++;
            if (!got || busy_cycles != 8) begin
                errors++;
                $display("FAIL mul_latency a=%h b=%h done_seen=%b busy_cycles=%0d want 8", va, vb, got, busy_cycles);
            end
            checks++;
            if ({busy, y, hi, overflow, bf} !== {1'b0, ey[7:0], eh[7:0], eo, ey[7:0] == 8'h00}) begin
                errors++;
                $display("FAIL mul_result a=%h b=%h got busy=%b y=%h hi=%h ovf=%b want y=%h hi=%h ovf=%b",
                         va, vb, busy, y, hi, overflow, ey[7:0], eh[7:0], eo);
            end
            if (i == 0) begin
                checks++;
                if ({y, hi, overflow} !== {8'h00, 8'h02, 1'b1}) begin
                    errors++;
                    $display("FAIL mul_10x20 got y=%h hi=%h ovf=%b want 00 02 1", y, hi, overflow);
                end
            end
            @(posedge clk); #1;
            checks++;
            if ({done, busy, y, hi} !== {2'b00, ey[7:0], eh[7:0]}) begin
                errors++;
                $display("FAIL mul_after got done=%b busy=%b y=%h hi=%h", done, busy, y, hi);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops  [4] = '{4'd2, 4'd3, 4'd8, 4'd4};
        logic [7:0] yexp [4] = '{8'h30, 8'hFC, 8'hCC, 8'h3C};
        longint unsigned ey, eh;
        logic eo;
        logic [3:0] o;
        for (int i = 0; i < 14; i++) begin
            if (i < 4) begin
                op = ops[i]; a = 8'hF0; b = 8'h3C;
            end else begin
                o = 4'($urandom_range(0, 14));
                if (o >= 4'd10) o = o + 4'd1;
                op = o; a = 8'($urandom); b = 8'($urandom_range(0, 12));
            end
            start = 1'b1;
            ref_model(8, int'(op), longint'(a), longint'(b), ey, eh, eo);
            @(posedge clk); #1;
            checks++;
            if ({done, y, hi, overflow} !== {1'b1, ey[7:0], 8'h00, eo}) begin
                errors++;
                $display("FAIL b2b idx=%0d got done=%b y=%h hi=%h ovf=%b want 1 %h 00 %b", i, done, y, hi, overflow, ey[7:0], eo);
            end
            if (i < 4) begin
                checks++;
                if ({y, overflow} !== {yexp[i], 1'b0}) begin
                    errors++;
                    $display("FAIL b2b_const idx=%0d got y=%h ovf=%b want %h 0", i, y, overflow, yexp[i]);
                end
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got done=%b want 0", done);
        end
    endtask

    task automatic test_reset_mid_mul();
        int dones;
        issue(4'hA, 8'h07, 8'h09);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({busy, done, y, hi, overflow, bf} !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL abort got busy=%b done=%b y=%h hi=%h ovf=%b bf=%b want 0 0 00 00 0 1",
                     busy, done, y, hi, overflow, bf);
        end
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            if (done || busy) dones++;
            @(posedge clk); #1;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_stale got %0d busy/done cycles want 0", dones);
        end
        issue(4'd0, 8'd1, 8'd1);
        checks++;
        if ({done, y, hi, overflow, bf} !== {1'b1, 8'h02, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_add got done=%b y=%h hi=%h ovf=%b want 1 02 00 0", done, y, hi, overflow);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, y} !== {1'b0, 8'h02}) begin
            errors++;
            $display("FAIL abort_add_hold got done=%b y=%h want 0 02", done, y);
        end
    endtask

    task automatic test_w16();
        longint unsigned ey, eh;
        logic eo;
        int edges;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin op16 = 4'hA; a16 = 16'h1234; b16 = 16'h0100; end
                1: begin op16 = 4'h0; a16 = 16'hFFFF; b16 = 16'h0001; end
                2: begin op16 = 4'h7; a16 = 16'h8001; b16 = 16'd16;   end
                3: begin op16 = 4'hA; a16 = 16'hFFFF; b16 = 16'hFFFF; end
                default: begin
                    op16 = ($urandom_range(0, 1) == 1) ? 4'hA : 4'($urandom_range(0, 9));
                    a16 = 16'($urandom); b16 = 16'($urandom);
                end
            endcase
            ref_model(16, int'(op16), longint'(a16), longint'(b16), ey, eh, eo);
            start16 = 1'b1;
            @(posedge clk); #1;
            start16 = 1'b0;
            edges = 1;
            while (!done16 && edges < 60) begin
                @(posedge clk); #1;
                edges++;
            end
            checks++;
            if (edges != ((op16 == 4'hA) ? 17 : 1)) begin
                errors++;
                $display("FAIL w16_latency op=%h got %0d edges done=%b", op16, edges, done16);
            end
            checks++;
            if ({done16, busy16, y16, hi16, ovf16, bf16} !== {2'b10, ey[15:0], eh[15:0], eo, ey[15:0] == 16'h0}) begin
                errors++;
                $display("FAIL w16 op=%h a=%h b=%h got y=%h hi=%h ovf=%b bf=%b want y=%h hi=%h ovf=%b",
                         op16, a16, b16, y16, hi16, ovf16, bf16, ey[15:0], eh[15:0], eo);
            end
            if (i == 0) begin
                checks++;
                if ({y16, hi16, ovf16} !== {16'h3400, 16'h0012, 1'b1}) begin
                    errors++;
                    $display("FAIL w16_mul_const got y=%h hi=%h ovf=%b want 3400 0012 1", y16, hi16, ovf16);
                end
            end
            if (i == 1) begin
                checks++;
                if ({y16, ovf16, bf16} !== {16'h0000, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL w16_add_const got y=%h ovf=%b bf=%b want 0000 1 1", y16, ovf16, bf16);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_w16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
